// File: rtl/spi_reg_device.sv
// SPI-style slave register file clocked by the system clock: decodes rw/address/data
// frames from cs/mosi, shifts read data out on miso, and exposes a combinational debug port.
module spi_reg_device #(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cs,
  input  logic              mosi,
  output logic              miso,
  output logic              done,
  input  logic [ADDR_W-1:0] dbg_addr,
  output logic [DATA_W-1:0] dbg_data
);

  localparam int DEPTH = 1 << ADDR_W;
  localparam int MAX_W = (ADDR_W > DATA_W) ? ADDR_W : DATA_W;
  localparam int CNT_W = $clog2(MAX_W + 1);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_ADDR  = 3'd1;
  localparam logic [2:0] S_WDATA = 3'd2;
  localparam logic [2:0] S_RDATA = 3'd3;
  localparam logic [2:0] S_WAIT  = 3'd4;

  logic [2:0]        state;
  logic              rw;
  logic [ADDR_W-1:0] addr_sh;
  logic [DATA_W-1:0] data_sh;
  logic [CNT_W-1:0]  bit_cnt;
  logic [DATA_W-1:0] mem [DEPTH];

  logic [ADDR_W-1:0] addr_next;
  logic [DATA_W-1:0] data_next;
  logic              last_addr;
  logic              last_data;

  // Values as they will look once the bit sampled on this edge is shifted in.
  assign addr_next = {addr_sh[ADDR_W-2:0], mosi};
  assign data_next = {data_sh[DATA_W-2:0], mosi};
  assign last_addr = (bit_cnt == CNT_W'(ADDR_W - 1));
  assign last_data = (bit_cnt == CNT_W'(DATA_W - 1));

  // Old value is visible until the write edge, new value the cycle after.
  assign dbg_data = mem[dbg_addr];

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= S_IDLE;
      rw      <= 1'b0;
      addr_sh <= '0;
      data_sh <= '0;
      bit_cnt <= '0;
      miso    <= 1'b0;
      done    <= 1'b0;
      // NOTE: the register file is built from flops so it can be cleared by reset;
      // a RAM macro would keep stale contents and break the reset behaviour.
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else begin
      // NOTE: done is defaulted low every cycle, so a single assignment below is a one-cycle pulse.
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (!cs) begin
            rw      <= mosi;
            bit_cnt <= '0;
            state   <= S_ADDR;
          end
        end

        S_ADDR: begin
          if (cs) begin
            state <= S_IDLE;
          end else begin
            addr_sh <= addr_next;
            if (last_addr) begin
              bit_cnt <= '0;
              if (rw) begin
                state <= S_WDATA;
              end else begin
                // miso is registered, so the first read bit is presented right after the address.
                data_sh <= mem[addr_next];
                miso    <= mem[addr_next][DATA_W-1];
                state   <= S_RDATA;
              end
            end else begin
              bit_cnt <= bit_cnt + CNT_W'(1);
            end
          end
        end

        S_WDATA: begin
          if (cs) begin
            state <= S_IDLE;
          end else begin
            data_sh <= data_next;
            if (last_data) begin
              mem[addr_sh] <= data_next;
              done         <= 1'b1;
              state        <= S_WAIT;
            end else begin
              bit_cnt <= bit_cnt + CNT_W'(1);
            end
          end
        end

        S_RDATA: begin
          if (cs) begin
            miso  <= 1'b0;
            state <= S_IDLE;
          end else begin
            data_sh <= data_sh << 1;
            if (last_data) begin
              miso  <= 1'b0;
              done  <= 1'b1;
              state <= S_WAIT;
            end else begin
              miso    <= data_sh[DATA_W-2];
              bit_cnt <= bit_cnt + CNT_W'(1);
            end
          end
        end

        S_WAIT: begin
          if (cs) begin
            state <= S_IDLE;
          end
        end

        default: begin
          miso  <= 1'b0;
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_spi_reg_device.sv
// Scoreboard bench for spi_reg_device: stimulus pushes timed expectations, a monitor
// compares done, miso and dbg_data after every rising edge.
module tb_spi_reg_device;

  logic       clk = 1'b0;
  logic       rst;
  logic       cs;
  logic       mosi;
  logic       miso;
  logic       done;
  logic [3:0] dbg_addr;
  logic [7:0] dbg_data;

  spi_reg_device #(.ADDR_W(4), .DATA_W(8)) dut (
    .clk      (clk),
    .rst      (rst),
    .cs       (cs),
    .mosi     (mosi),
    .miso     (miso),
    .done     (done),
    .dbg_addr (dbg_addr),
    .dbg_data (dbg_data)
  );

  always #5 clk = ~clk;

  localparam int K_MISO = 0;
  localparam int K_DBG  = 1;

  typedef struct {
    int cyc;
    int kind;
    int val;
  } exp_t;

  exp_t       chk_q[$];
  int         done_q[$];
  int         cyc = 0;
  int         tests = 0;
  int         fails = 0;
  logic [7:0] model [16];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s @cycle %0d: got %0h, expected %0h", name, cyc, act, exp);
    end
  endtask

  task automatic push_chk(input int c, input int kind, input int val);
    exp_t r;
    r.cyc  = c;
    r.kind = kind;
    r.val  = val;
    chk_q.push_back(r);
  endtask

  // Monitor: one pass per rising edge, sampled 1 time unit after the edge.
  always begin
    bit   exp_done;
    exp_t r;
    @(posedge clk);
    cyc++;
    #1;
    exp_done = (done_q.size() > 0) && (done_q[0] == cyc);
    if (exp_done) void'(done_q.pop_front());
    check("done", 32'(done), 32'(exp_done));
    while (chk_q.size() > 0 && chk_q[0].cyc <= cyc) begin
      r = chk_q.pop_front();
      if (r.cyc != cyc)
        check("stale_expectation", 32'(r.cyc), 32'(cyc));
      else if (r.kind == K_MISO)
        check("miso", 32'(miso), 32'(r.val));
      else
        check("dbg_data", 32'(dbg_data), 32'(r.val));
    end
  end

  // Drives one frame of nbits with cs low, then one idle bit with cs high.
  task automatic send_frame(input bit rw, input int addr, input int data, input int nbits);
    logic [12:0] fr;
    logic [7:0]  d;
    int          e;
    d  = data[7:0];
    fr = {rw, addr[3:0], d};
    dbg_addr = addr[3:0];
    for (int k = 0; k < nbits; k++) begin
      @(negedge clk);
      cs = 1'b0;
      if (k >= 13)               mosi = 1'($urandom_range(0, 1));
      else if (!rw && k >= 5)    mosi = 1'b1;
      else                       mosi = fr[12-k];
      e = cyc + 1;
      if (rw) begin
        push_chk(e, K_MISO, 0);
        if (nbits >= 13 && k == 11) push_chk(e, K_DBG, int'(model[addr[3:0]]));
        if (nbits >= 13 && k == 12) begin
          push_chk(e, K_DBG, int'(d));
          done_q.push_back(e);
        end
      end else begin
        if (k < 4 || k >= 12) push_chk(e, K_MISO, 0);
        else                  push_chk(e, K_MISO, int'(d[11-k]));
        if (nbits >= 13 && k == 12) done_q.push_back(e);
      end
    end
    if (rw && nbits >= 13) model[addr[3:0]] = d;
    @(negedge clk);
    cs   = 1'b1;
    mosi = 1'b0;
    push_chk(cyc + 1, K_MISO, 0);
  endtask

  task automatic dbg_sweep();
    for (int a = 0; a < 16; a++) begin
      @(negedge clk);
      dbg_addr = 4'(a);
      push_chk(cyc + 1, K_DBG, int'(model[a]));
    end
  endtask

  initial begin
    rst      = 1'b1;
    cs       = 1'b1;
    mosi     = 1'b0;
    dbg_addr = '0;
    for (int a = 0; a < 16; a++) model[a] = 8'h00;
    repeat (3) begin
      @(negedge clk);
      push_chk(cyc + 1, K_MISO, 0);
    end
    @(negedge clk);
    rst = 1'b0;
    dbg_sweep();

    // Preload a register so the mid-stream reset has something to clear.
    send_frame(1'b1, 7, 8'h3C, 13);

    // Reset asserted for 10 cycles in the middle of a write frame.
    dbg_addr = 4'd7;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      cs   = 1'b0;
      mosi = (k == 0) ? 1'b1 : 1'(k & 1);
      push_chk(cyc + 1, K_MISO, 0);
    end
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      rst  = 1'b1;
      mosi = 1'(k & 1);
      push_chk(cyc + 1, K_MISO, 0);
      if (k > 0) push_chk(cyc + 1, K_DBG, 0);
    end
    for (int a = 0; a < 16; a++) model[a] = 8'h00;
    @(negedge clk);
    rst = 1'b0;
    cs  = 1'b1;
    dbg_sweep();

    // Write 0xA3 to address 5, then every other register must still read 0.
    send_frame(1'b1, 5, 8'hA3, 13);
    dbg_sweep();

    // Read-back: 0x5C at address 15 shifts out as 0,1,0,1,1,1,0,0.
    send_frame(1'b1, 15, 8'h5C, 13);
    send_frame(1'b0, 15, 8'h5C, 13);

    // Abort after 8 edges leaves address 3 untouched; the full write then lands.
    send_frame(1'b1, 3, 8'h77, 8);
    @(negedge clk);
    dbg_addr = 4'd3;
    push_chk(cyc + 1, K_DBG, 0);
    send_frame(1'b1, 3, 8'hFF, 13);

    // Overlong frame: trailing bits ignored, next frame still works.
    send_frame(1'b1, 9, 8'h6B, 20);
    send_frame(1'b0, 9, 8'h6B, 13);

    // Back-to-back writes separated by a single cs-high cycle.
    send_frame(1'b1, 0, 8'h11, 13);
    send_frame(1'b1, 1, 8'h22, 13);
    dbg_sweep();

    repeat (4) @(negedge clk);
    check("pending_done", 32'(done_q.size()), 32'd0);
    check("pending_checks", 32'(chk_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
